// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command responder:
// frame headers, command and status codes, frame lengths, FSM states.
package uart_cmd_pkg;

    // Default frame header bytes (the top module exposes these as parameters)
    localparam logic [7:0] HDR_CMD_DEF = 8'hA5;
    localparam logic [7:0] HDR_RSP_DEF = 8'h5A;

    // Command codes carried in the CMD byte
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    // Status codes returned in the STATUS byte
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_CHK_ERR = 8'hE1;
    localparam logic [7:0] ST_BAD_CMD = 8'hE2;

    // Frame lengths in bytes, header included
    localparam int RX_FRAME_LEN = 5;
    localparam int TX_FRAME_LEN = 4;

    // Responder FSM states
    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_CMD,
        S_GET_ADDR,
        S_GET_DATA,
        S_GET_CHK,
        S_EXEC,
        S_RD_WAIT,
        S_TX_LOAD,
        S_TX_WAIT
    } state_t;

    // Checksum over the three payload bytes of a command frame
    function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
        return cmd ^ addr ^ data;
    endfunction

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Bundle of the UART byte handshakes and the local register bus seen by
// the command responder. master = responder side, slave = environment side.
interface uart_cmd_responder_if;

    // UART receive side
    logic       rxd_flag;
    logic [7:0] rxd_data;
    // UART transmit side
    logic       txd_en;
    logic [7:0] txd_data;
    logic       txd_flag;
    // Local register bus
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    // Frame in progress
    logic       busy;

    modport master (
        input  rxd_flag, rxd_data, txd_flag, reg_rdata,
        output txd_en, txd_data, reg_wr, reg_rd, reg_addr, reg_wdata, busy
    );

    modport slave (
        output rxd_flag, rxd_data, txd_flag, reg_rdata,
        input  txd_en, txd_data, reg_wr, reg_rd, reg_addr, reg_wdata, busy
    );

endinterface

// File: rtl/uart_cmd_responder.sv
// UART command responder: parses 5-byte command frames from the UART
// receiver, performs one register read or write on the local bus and
// answers with a 4-byte response frame over the UART transmit handshake.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50000000,  // informational only
    parameter int unsigned TIMEOUT_CYC = 5000000,   // inter-byte timeout, clk cycles
    parameter logic [7:0]  HDR_CMD     = HDR_CMD_DEF,
    parameter logic [7:0]  HDR_RSP     = HDR_RSP_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_cmd_responder_if.master   bus
);

    // The frame walker below is hard-wired for this frame layout, and the
    // timeout counter needs at least two states to be meaningful.
    if (CLK_FREQ == 0 || TIMEOUT_CYC < 2 ||
        RX_FRAME_LEN != 5 || TX_FRAME_LEN != 4) begin : g_bad_cfg
        $error("uart_cmd_responder: unsupported parameter set");
    end

    localparam int             TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]     TX_LAST  = 2'(TX_FRAME_LEN - 1);

    state_t             state_q,     state_d;
    logic [1:0]         idx_q,       idx_d;        // response byte index
    logic [7:0]         cmd_q,       cmd_d;
    logic [7:0]         addr_q,      addr_d;
    logic [7:0]         data_q,      data_d;
    logic [7:0]         chk_q,       chk_d;
    logic [7:0]         status_q,    status_d;
    logic [7:0]         rdata_q,     rdata_d;
    logic [7:0]         reg_addr_q,  reg_addr_d;   // bus address held between EXECs
    logic [7:0]         reg_wdata_q, reg_wdata_d;  // bus write data held between EXECs
    logic [TMO_W-1:0]   tmo_q,       tmo_d;

    logic               reg_wr;
    logic               reg_rd;
    logic               txd_en;
    logic               tx_active;
    logic [7:0]         rsp_byte;

    // State and frame latches; async reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            chk_q       <= '0;
            status_q    <= '0;
            rdata_q     <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            chk_q       <= chk_d;
            status_q    <= status_d;
            rdata_q     <= rdata_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            tmo_q       <= tmo_d;
        end
    end

    // Next-state logic: frame reception, execution and response sequencing
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        chk_d       = chk_q;
        status_d    = status_q;
        rdata_d     = rdata_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        tmo_d       = tmo_q;
        reg_wr      = 1'b0;
        reg_rd      = 1'b0;
        txd_en      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                // Anything other than a header byte is line noise
                if (bus.rxd_flag && bus.rxd_data == HDR_CMD) begin
                    state_d = S_GET_CMD;
                end
            end

            S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK: begin
                // A received byte beats a timeout expiring in the same cycle
                if (bus.rxd_flag) begin
                    tmo_d = '0;
                    unique case (state_q)
                        S_GET_CMD: begin
                            cmd_d   = bus.rxd_data;
                            state_d = S_GET_ADDR;
                        end
                        S_GET_ADDR: begin
                            addr_d  = bus.rxd_data;
                            state_d = S_GET_DATA;
                        end
                        S_GET_DATA: begin
                            data_d  = bus.rxd_data;
                            state_d = S_GET_CHK;
                        end
                        default: begin
                            chk_d   = bus.rxd_data;
                            state_d = S_EXEC;
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    // Stalled frame: drop it silently
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_EXEC: begin
                reg_addr_d  = addr_q;
                reg_wdata_d = data_q;
                rdata_d     = 8'h00;
                idx_d       = '0;
                state_d     = S_TX_LOAD;
                // Checksum is judged before the command code
                if (frame_chk(cmd_q, addr_q, data_q) != chk_q) begin
                    status_d = ST_CHK_ERR;
                end else if (cmd_q == CMD_WR) begin
                    reg_wr   = 1'b1;
                    status_d = ST_OK;
                end else if (cmd_q == CMD_RD) begin
                    reg_rd   = 1'b1;
                    status_d = ST_OK;
                    state_d  = S_RD_WAIT;
                end else begin
                    status_d = ST_BAD_CMD;
                end
            end

            S_RD_WAIT: begin
                // Register file returns read data one cycle after the strobe
                rdata_d = bus.reg_rdata;
                state_d = S_TX_LOAD;
            end

            S_TX_LOAD: begin
                txd_en  = 1'b1;
                state_d = S_TX_WAIT;
            end

            S_TX_WAIT: begin
                if (bus.txd_flag) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q == TX_LAST) ? S_IDLE : S_TX_LOAD;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Response byte selected by the transmit index
    always_comb begin
        rsp_byte = 8'h00;
        unique case (idx_q)
            2'd0:    rsp_byte = HDR_RSP;
            2'd1:    rsp_byte = status_q;
            2'd2:    rsp_byte = rdata_q;
            default: rsp_byte = status_q ^ rdata_q;
        endcase
    end

    assign tx_active = (state_q == S_TX_LOAD) || (state_q == S_TX_WAIT);

    // During EXEC the bus sees the freshly received address/data so the
    // strobe and its operands line up; afterwards the held copies persist.
    assign bus.reg_addr  = (state_q == S_EXEC) ? addr_q : reg_addr_q;
    assign bus.reg_wdata = (state_q == S_EXEC) ? data_q : reg_wdata_q;
    assign bus.reg_wr    = reg_wr;
    assign bus.reg_rd    = reg_rd;
    assign bus.txd_en    = txd_en;
    assign bus.txd_data  = tx_active ? rsp_byte : 8'h00;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed self-checking bench for uart_cmd_responder.
module tb_uart_cmd_responder;

    localparam int TMO = 40;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // Captured response frame and capture status
    logic [7:0] cap [4];
    int         cap_ok;
    int         cap_glitch;

    // Bus strobe counters
    int wr_cnt;
    int rd_cnt;

    uart_cmd_responder_if bus ();

    uart_cmd_responder #(
        .CLK_FREQ    (50000000),
        .TIMEOUT_CYC (TMO),
        .HDR_CMD     (8'hA5),
        .HDR_RSP     (8'h5A)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count bus strobes mid-cycle
    always @(negedge clk) begin
        if (bus.reg_wr === 1'b1) wr_cnt <= wr_cnt + 1;
        if (bus.reg_rd === 1'b1) rd_cnt <= rd_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rxd_flag = 1'b1;
        bus.rxd_data = b;
        tick();
        bus.rxd_flag = 1'b0;
        bus.rxd_data = 8'h00;
    endtask

    // Collect a 4-byte response, delaying each txd_flag by 3 cycles and
    // recording whether txd_en re-fired or txd_data moved meanwhile.
    task automatic capture_rsp();
        cap_ok     = 1;
        cap_glitch = 0;
        for (int k = 0; k < 4; k++) cap[k] = 8'hxx;
        for (int k = 0; k < 4; k++) begin
            int n;
            n = 0;
            while (bus.txd_en !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            if (bus.txd_en !== 1'b1) begin
                cap_ok = 0;
                return;
            end
            cap[k] = bus.txd_data;
            for (int w = 0; w < 3; w++) begin
                tick();
                if (bus.txd_en === 1'b1 || bus.txd_data !== cap[k]) cap_glitch = 1;
            end
            bus.txd_flag = 1'b1;
            tick();
            bus.txd_flag = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.txd_en !== 1'b0) begin failures++; $display("FAIL reset_txd_en: got %b want 0", bus.txd_en); end
        checks++; if (bus.reg_wr !== 1'b0 || bus.reg_rd !== 1'b0) begin failures++; $display("FAIL reset_strobes: got wr=%b rd=%b want 0/0", bus.reg_wr, bus.reg_rd); end
        checks++; if (bus.reg_addr !== 8'h00 || bus.reg_wdata !== 8'h00 || bus.txd_data !== 8'h00) begin failures++; $display("FAIL reset_data: got addr=%h wdata=%h txd=%h want 00", bus.reg_addr, bus.reg_wdata, bus.txd_data); end
        rst_n = 1'b1;
        tick();
        $display("reset: busy=%b txd_en=%b", bus.busy, bus.txd_en);
    endtask

    task automatic test_write();
        int wr0, rd0;
        wr0 = wr_cnt; rd0 = rd_cnt;
        send_byte(8'hA5);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL write_busy: got %b want 1", bus.busy); end
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h2D);
        checks++; if (bus.reg_wr !== 1'b1 || bus.reg_rd !== 1'b0) begin failures++; $display("FAIL write_strobe: got wr=%b rd=%b want 1/0", bus.reg_wr, bus.reg_rd); end
        checks++; if (bus.reg_addr !== 8'h10 || bus.reg_wdata !== 8'h3C) begin failures++; $display("FAIL write_bus: got addr=%h wdata=%h want 10/3c", bus.reg_addr, bus.reg_wdata); end
        checks++; if (bus.txd_en !== 1'b0) begin failures++; $display("FAIL write_early_tx: got txd_en=%b want 0", bus.txd_en); end
        tick();
        checks++; if (bus.txd_en !== 1'b1 || bus.reg_wr !== 1'b0) begin failures++; $display("FAIL write_tx_latency: got txd_en=%b wr=%b want 1/0", bus.txd_en, bus.reg_wr); end
        capture_rsp();
        checks++; if (cap_ok !== 1 || cap_glitch !== 0) begin failures++; $display("FAIL write_handshake: got ok=%0d glitch=%0d want 1/0", cap_ok, cap_glitch); end
        checks++; if ({cap[0], cap[1], cap[2], cap[3]} !== 32'h5A000000) begin failures++; $display("FAIL write_rsp: got %h %h %h %h want 5a 00 00 00", cap[0], cap[1], cap[2], cap[3]); end
        checks++; if (wr_cnt - wr0 !== 1 || rd_cnt - rd0 !== 0) begin failures++; $display("FAIL write_count: got wr=%0d rd=%0d want 1/0", wr_cnt - wr0, rd_cnt - rd0); end
        checks++; if (bus.busy !== 1'b0 || bus.reg_addr !== 8'h10 || bus.reg_wdata !== 8'h3C) begin failures++; $display("FAIL write_hold: got busy=%b addr=%h wdata=%h want 0/10/3c", bus.busy, bus.reg_addr, bus.reg_wdata); end
        $display("write frame: rsp %h %h %h %h", cap[0], cap[1], cap[2], cap[3]);
    endtask

    task automatic test_read();
        int wr0, rd0;
        wr0 = wr_cnt; rd0 = rd_cnt;
        bus.reg_rdata = 8'h00;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h22); send_byte(8'h00); send_byte(8'h20);
        checks++; if (bus.reg_rd !== 1'b1 || bus.reg_wr !== 1'b0 || bus.reg_addr !== 8'h22) begin failures++; $display("FAIL read_strobe: got rd=%b wr=%b addr=%h want 1/0/22", bus.reg_rd, bus.reg_wr, bus.reg_addr); end
        tick();
        // read data is presented only in the cycle after the strobe
        bus.reg_rdata = 8'h7E;
        checks++; if (bus.txd_en !== 1'b0 || bus.reg_rd !== 1'b0) begin failures++; $display("FAIL read_wait: got txd_en=%b rd=%b want 0/0", bus.txd_en, bus.reg_rd); end
        tick();
        bus.reg_rdata = 8'hFF;
        checks++; if (bus.txd_en !== 1'b1) begin failures++; $display("FAIL read_tx_latency: got txd_en=%b want 1", bus.txd_en); end
        capture_rsp();
        checks++; if (cap_ok !== 1 || cap_glitch !== 0) begin failures++; $display("FAIL read_handshake: got ok=%0d glitch=%0d want 1/0", cap_ok, cap_glitch); end
        checks++; if ({cap[0], cap[1], cap[2], cap[3]} !== 32'h5A007E7E) begin failures++; $display("FAIL read_rsp: got %h %h %h %h want 5a 00 7e 7e", cap[0], cap[1], cap[2], cap[3]); end
        checks++; if (wr_cnt - wr0 !== 0 || rd_cnt - rd0 !== 1) begin failures++; $display("FAIL read_count: got wr=%0d rd=%0d want 0/1", wr_cnt - wr0, rd_cnt - rd0); end
        bus.reg_rdata = 8'h00;
        $display("read frame: rsp %h %h %h %h", cap[0], cap[1], cap[2], cap[3]);
    endtask

    task automatic test_bad_chk();
        int wr0, rd0;
        wr0 = wr_cnt; rd0 = rd_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h00);
        checks++; if (bus.reg_wr !== 1'b0 || bus.reg_rd !== 1'b0) begin failures++; $display("FAIL badchk_strobe: got wr=%b rd=%b want 0/0", bus.reg_wr, bus.reg_rd); end
        capture_rsp();
        checks++; if (cap_ok !== 1 || {cap[0], cap[1], cap[2], cap[3]} !== 32'h5AE100E1) begin failures++; $display("FAIL badchk_rsp: got ok=%0d %h %h %h %h want 5a e1 00 e1", cap_ok, cap[0], cap[1], cap[2], cap[3]); end
        checks++; if (wr_cnt - wr0 !== 0 || rd_cnt - rd0 !== 0) begin failures++; $display("FAIL badchk_count: got wr=%0d rd=%0d want 0/0", wr_cnt - wr0, rd_cnt - rd0); end
        $display("bad checksum frame: rsp %h %h %h %h", cap[0], cap[1], cap[2], cap[3]);
    endtask

    task automatic test_bad_cmd();
        int wr0, rd0;
        wr0 = wr_cnt; rd0 = rd_cnt;
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h2B);
        capture_rsp();
        checks++; if (cap_ok !== 1 || {cap[0], cap[1], cap[2], cap[3]} !== 32'h5AE200E2) begin failures++; $display("FAIL badcmd_rsp: got ok=%0d %h %h %h %h want 5a e2 00 e2", cap_ok, cap[0], cap[1], cap[2], cap[3]); end
        checks++; if (wr_cnt - wr0 !== 0 || rd_cnt - rd0 !== 0) begin failures++; $display("FAIL badcmd_count: got wr=%0d rd=%0d want 0/0", wr_cnt - wr0, rd_cnt - rd0); end
        $display("bad command frame: rsp %h %h %h %h", cap[0], cap[1], cap[2], cap[3]);
    endtask

    task automatic test_hdr_payload();
        // 01 ^ A5 ^ A5 = 01: header value used as address and data
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h01);
        checks++; if (bus.reg_wr !== 1'b1 || bus.reg_addr !== 8'hA5 || bus.reg_wdata !== 8'hA5) begin failures++; $display("FAIL hdrpay_bus: got wr=%b addr=%h wdata=%h want 1/a5/a5", bus.reg_wr, bus.reg_addr, bus.reg_wdata); end
        capture_rsp();
        checks++; if (cap_ok !== 1 || {cap[0], cap[1], cap[2], cap[3]} !== 32'h5A000000) begin failures++; $display("FAIL hdrpay_rsp: got ok=%0d %h %h %h %h want 5a 00 00 00", cap_ok, cap[0], cap[1], cap[2], cap[3]); end
        $display("header-as-payload frame: rsp %h %h %h %h", cap[0], cap[1], cap[2], cap[3]);
    endtask

    task automatic test_timeout();
        int wr0, tx_seen;
        wr0 = wr_cnt;
        tx_seen = 0;
        send_byte(8'h33);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL tmo_garbage: got busy=%b want 0", bus.busy); end
        send_byte(8'hA5); send_byte(8'h01);
        // counter restarted at 0 on the last byte; expiry takes TMO cycles
        repeat (TMO - 1) begin
            tick();
            if (bus.txd_en === 1'b1) tx_seen = 1;
        end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL tmo_early: got busy=%b want 1", bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL tmo_expire: got busy=%b want 0", bus.busy); end
        repeat (5) begin
            tick();
            if (bus.txd_en === 1'b1) tx_seen = 1;
        end
        checks++; if (tx_seen !== 0 || wr_cnt - wr0 !== 0) begin failures++; $display("FAIL tmo_silent: got tx=%0d wr=%0d want 0/0", tx_seen, wr_cnt - wr0); end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h2D);
        checks++; if (bus.reg_wr !== 1'b1 || bus.reg_addr !== 8'h10) begin failures++; $display("FAIL tmo_next_wr: got wr=%b addr=%h want 1/10", bus.reg_wr, bus.reg_addr); end
        capture_rsp();
        checks++; if (cap_ok !== 1 || {cap[0], cap[1], cap[2], cap[3]} !== 32'h5A000000) begin failures++; $display("FAIL tmo_next_rsp: got ok=%0d %h %h %h %h want 5a 00 00 00", cap_ok, cap[0], cap[1], cap[2], cap[3]); end
        $display("timeout then frame: rsp %h %h %h %h", cap[0], cap[1], cap[2], cap[3]);
    endtask

    task automatic test_reset_mid_tx();
        int n;
        int got;
        got = 0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h2D);
        // acknowledge bytes 0 and 1, then stop inside TX_WAIT of byte 2
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (bus.txd_en !== 1'b1 && n < 20) begin tick(); n++; end
            if (bus.txd_en === 1'b1) got++;
            tick();
            if (k < 2) begin
                bus.txd_flag = 1'b1;
                tick();
                bus.txd_flag = 1'b0;
            end
        end
        checks++; if (got !== 3 || bus.busy !== 1'b1) begin failures++; $display("FAIL rstmid_setup: got bytes=%0d busy=%b want 3/1", got, bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.txd_en !== 1'b0 || bus.txd_data !== 8'h00) begin failures++; $display("FAIL rstmid_tx: got busy=%b txd_en=%b txd=%h want 0/0/00", bus.busy, bus.txd_en, bus.txd_data); end
        checks++; if (bus.reg_wr !== 1'b0 || bus.reg_rd !== 1'b0 || bus.reg_addr !== 8'h00 || bus.reg_wdata !== 8'h00) begin failures++; $display("FAIL rstmid_bus: got wr=%b rd=%b addr=%h wdata=%h want 0", bus.reg_wr, bus.reg_rd, bus.reg_addr, bus.reg_wdata); end
        tick();
        rst_n = 1'b1;
        tick();
        bus.reg_rdata = 8'h00;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h22); send_byte(8'h00); send_byte(8'h20);
        tick();
        bus.reg_rdata = 8'h7E;
        tick();
        bus.reg_rdata = 8'h00;
        capture_rsp();
        checks++; if (cap_ok !== 1 || cap_glitch !== 0 || {cap[0], cap[1], cap[2], cap[3]} !== 32'h5A007E7E) begin failures++; $display("FAIL rstmid_next_rsp: got ok=%0d %h %h %h %h want 5a 00 7e 7e", cap_ok, cap[0], cap[1], cap[2], cap[3]); end
        $display("reset mid-transmit then read: rsp %h %h %h %h", cap[0], cap[1], cap[2], cap[3]);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        wr_cnt        = 0;
        rd_cnt        = 0;
        rst_n         = 1'b0;
        bus.rxd_flag  = 1'b0;
        bus.rxd_data  = 8'h00;
        bus.txd_flag  = 1'b0;
        bus.reg_rdata = 8'h00;

        test_reset();
        test_write();
        test_read();
        test_bad_chk();
        test_bad_cmd();
        test_hdr_payload();
        test_timeout();
        test_reset_mid_tx();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
